// File: rtl/mcu_sample_feeder.sv
// -----------------------------------------------------------------------------
// mcu_sample_feeder
//
// Streams samples from a local buffer to an ASIC over a register-level
// ready/valid/ack handshake and captures the ASIC's result for each sample.
//
// A run is requested with a one-cycle start pulse carrying num_samples
// (clamped to DEPTH). The feeder waits once for ASIC ready, then for each
// sample: loads it into the SampleIn registers and raises "sample valid",
// waits for the ASIC ack, captures the result, waits for ack to drop, and
// moves on. A one-cycle done pulse closes the run. abort cancels a run at
// any point without a done pulse.
//
// Parameters
//   WIDTH    sample/result width (split into msb/lsb bytes)
//   DEPTH    sample buffer entries; AW = clog2(DEPTH)
//   TIMEOUT  handshake wait limit in clocks (only with FEEDER_TIMEOUT_EN)
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   buf_wr_en/addr/data     buffer write port, accepted only while idle
//   start, num_samples      run request and sample count
//   abort                   cancel the current run
//   myRegMCUStatuslsb/msb   to ASIC: lsb bit0 = busy, lsb bit2 = sample valid
//   myRegSampleInlsb/msb    to ASIC: current sample
//   myRegASICStatuslsb/msb  from ASIC: lsb bit2 = ready, lsb bit3 = ack
//   myRegResultslsb/msb     from ASIC: result for the current sample
//   result_valid/data/index captured result stream (one-cycle strobe)
//   busy, done, error       run status; done is a pulse, error is sticky
//
// Configuration
//   FEEDER_TIMEOUT_EN  when defined, each handshake wait is bounded by
//                      TIMEOUT clocks; expiry parks the feeder in ERROR with
//                      error=1 until the next start or reset. When undefined
//                      the feeder waits indefinitely and error is tied low.
// -----------------------------------------------------------------------------
module mcu_sample_feeder #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 128,
  parameter int TIMEOUT = 1024,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             buf_wr_en,
  input  logic [AW-1:0]    buf_wr_addr,
  input  logic [WIDTH-1:0] buf_wr_data,
  input  logic             start,
  input  logic [7:0]       num_samples,
  input  logic             abort,
  output logic [7:0]       myRegMCUStatuslsb,
  output logic [7:0]       myRegMCUStatusmsb,
  output logic [7:0]       myRegSampleInlsb,
  output logic [7:0]       myRegSampleInmsb,
  input  logic [7:0]       myRegASICStatuslsb,
  input  logic [7:0]       myRegASICStatusmsb,
  input  logic [7:0]       myRegResultslsb,
  input  logic [7:0]       myRegResultsmsb,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_data,
  output logic [AW-1:0]    result_index,
  output logic             busy,
  output logic             done,
  output logic             error
);

`ifdef FEEDER_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE, WAIT_READY, LOAD, WAIT_ACK, WAIT_RELEASE, DONE, ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WAIT_READY, LOAD, WAIT_ACK, WAIT_RELEASE, DONE
  } state_t;
`endif

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    index;
  logic [AW-1:0]    count_m1;     // last index of the run (count - 1)
  logic [AW-1:0]    count_m1_d;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;

  logic asic_ready;
  logic asic_ack;
  logic last;

  // Control strobes from the next-state logic to the datapath.
  logic run_start;
  logic load_sample;
  logic capture;
  logic advance;
  logic finish;
  logic clear_err;

  assign asic_ready = myRegASICStatuslsb[2];
  assign asic_ack   = myRegASICStatuslsb[3];
  assign last       = (index == count_m1);

  // Only the ready/ack bits of the ASIC status carry meaning.
  logic unused_status;
  assign unused_status = ^{myRegASICStatusmsb, myRegASICStatuslsb[7:4],
                           myRegASICStatuslsb[1:0]};

`ifdef FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;
  logic          waiting;
  logic          tmo;
  logic          enter_error;

  assign waiting = (state_q inside {WAIT_READY, WAIT_ACK, WAIT_RELEASE});
  assign tmo     = (wait_cnt == TW'(TIMEOUT - 1));
  assign busy    = !(state_q inside {IDLE, ERROR});
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT[0];
  assign busy           = (state_q != IDLE);
  assign error          = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d     = state_q;
    run_start   = 1'b0;
    load_sample = 1'b0;
    capture     = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    clear_err   = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
    enter_error = 1'b0;
`endif

    // Requests above the buffer size run the whole buffer.
    if (int'(num_samples) > DEPTH) count_m1_d = AW'(DEPTH - 1);
    else                           count_m1_d = AW'(num_samples - 8'd1);

    case (state_q)
      WAIT_READY: begin
        if (asic_ready) state_d = LOAD;
      end
      LOAD: begin
        load_sample = 1'b1;
        state_d     = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (asic_ack) begin
          capture = 1'b1;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!asic_ack) begin
          if (last) begin
            state_d = DONE;
          end else begin
            advance = 1'b1;
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        // IDLE (and ERROR): a run request is the only way forward.
        if (start) begin
          clear_err = 1'b1;
          if (num_samples != 8'd0) begin
            run_start = 1'b1;
            state_d   = WAIT_READY;
          end else begin
            state_d = DONE;
          end
        end
      end
    endcase

`ifdef FEEDER_TIMEOUT_EN
    // A wait that made no progress this cycle and has run out of budget.
    if (waiting && tmo && (state_d == state_q)) begin
      state_d     = ERROR;
      enter_error = 1'b1;
    end
`endif

    // abort overrides every transition and suppresses all side effects.
    if (abort) begin
      state_d     = IDLE;
      run_start   = 1'b0;
      load_sample = 1'b0;
      capture     = 1'b0;
      advance     = 1'b0;
      finish      = 1'b0;
      clear_err   = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      enter_error = 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Sample buffer
  // ---------------------------------------------------------------------------
  // NOTE: the buffer array has no reset; its contents are undefined after
  // reset, and leaving it out keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (buf_wr_en && !busy) mem[buf_wr_addr] <= buf_wr_data;
  end

  // ---------------------------------------------------------------------------
  // Datapath: run index, sample registers, result capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      index        <= '0;
      count_m1     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_index <= '0;
      done         <= 1'b0;
    end else begin
      result_valid <= capture;
      done         <= finish;
      if (run_start) begin
        index    <= '0;
        count_m1 <= count_m1_d;
      end
      // The sample register doubles as the buffer's synchronous read port,
      // so SampleIn only changes on a LOAD.
      if (load_sample) begin
        sample       <= mem[index];
        sample_valid <= 1'b1;
      end
      if (capture) begin
        result_data  <= WIDTH'({myRegResultsmsb, myRegResultslsb});
        result_index <= index;
        sample_valid <= 1'b0;
      end
      if (advance) index <= index + 1'b1;
      if (abort)   sample_valid <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      if (enter_error) sample_valid <= 1'b0;
`endif
    end
  end

`ifdef FEEDER_TIMEOUT_EN
  // Wait counter restarts whenever the state changes and only runs while
  // the feeder sits in one of the handshake waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      error    <= 1'b0;
    end else begin
      if (state_d != state_q) wait_cnt <= '0;
      else if (waiting)       wait_cnt <= wait_cnt + 1'b1;

      if (enter_error)    error <= 1'b1;
      else if (clear_err) error <= 1'b0;
    end
  end
`else
  logic unused_clear;
  assign unused_clear = clear_err;
`endif

  // ---------------------------------------------------------------------------
  // Register-map outputs
  // ---------------------------------------------------------------------------
  assign myRegMCUStatuslsb = {5'b0, sample_valid, 1'b0, busy};
  assign myRegMCUStatusmsb = 8'h00;
  assign myRegSampleInmsb  = sample[WIDTH-1 -: 8];
  assign myRegSampleInlsb  = sample[7:0];

endmodule
